// File: rtl/gen_exp_mc.sv
// gen_exp_mc: multi-channel exponential generator, f_k(t) = alpha_k * delta_k^t.
// Unsigned Q(W-F).F values; one shared W x W multiplier is time-multiplexed
// across the channels, one slot per cycle, in a sweep started by i_tick.
module gen_exp_mc #(
  parameter int W  = 26,
  parameter int F  = 24,
  parameter int CH = 4,
  parameter int CW = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_load,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] i_load_ch,
  input  logic [W-1:0]                        i_alpha,
  input  logic [W-1:0]                        i_delta,
  input  logic [CW-1:0]                       i_steps,
  input  logic [W-1:0]                        i_floor,
  input  logic                                i_tick,
  output logic [CH*W-1:0]                     o_val,
  output logic [CH-1:0]                       o_active,
  output logic [CH-1:0]                       o_done,
  output logic                                o_busy,
  output logic                                o_upd,
  output logic                                o_ovr
);

  localparam int LCW = (CH > 1) ? $clog2(CH) : 1;
  localparam int RW  = 2*W - F + 1;   // width of the rounded product

  typedef enum logic {IDLE, RUN} state_t;

  // Round a full 2W-bit product half-up and drop F fractional bits.
  function automatic logic [RW-1:0] round_half_up(input logic [2*W-1:0] p);
    logic [2*W:0] sum;
    sum = {1'b0, p} + ((2*W+1)'(1) << (F-1));
    return sum[2*W:F];
  endfunction

  // Clamp the rounded product to the W-bit unsigned range.
  function automatic logic [W-1:0] saturate(input logic [RW-1:0] r);
    if (|r[RW-1:W]) return {W{1'b1}};
    return r[W-1:0];
  endfunction

  // Per-channel state
  logic [W-1:0]  val_q   [CH];
  logic [W-1:0]  delta_q [CH];
  logic [W-1:0]  floor_q [CH];
  logic [CW-1:0] steps_q [CH];
  logic [CH-1:0] active_q;
  logic [CH-1:0] done_q;

  // Sweep control
  state_t         state_q;
  logic [LCW-1:0] idx_q;
  logic           busy_q;
  logic           upd_q;
  logic           ovr_q;

  // Stage p0: shared multiplier and slot results for channel idx_q
  logic [2*W-1:0] prod_p0;
  logic [W-1:0]   val_new_p0;
  logic [CW-1:0]  steps_new_p0;
  logic           term_p0;
  logic           slot_en_p0;
  logic           load_ok;

  // Slot datapath: multiply, round, saturate, evaluate termination.
  always_comb begin
    prod_p0      = val_q[idx_q] * delta_q[idx_q];
    val_new_p0   = saturate(round_half_up(prod_p0));
    steps_new_p0 = (steps_q[idx_q] != '0) ? steps_q[idx_q] - CW'(1) : '0;
    term_p0      = ((steps_q[idx_q] == CW'(1))) ||
                   ((floor_q[idx_q] != '0) && (val_new_p0 <= floor_q[idx_q]));
    slot_en_p0   = (state_q == RUN) && active_q[idx_q];
    load_ok      = i_load && (int'(i_load_ch) < CH);
  end

  // Channel registers: slot update first, a load to the same channel overrides it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < CH; k++) begin
        val_q[k]   <= '0;
        delta_q[k] <= '0;
        floor_q[k] <= '0;
        steps_q[k] <= '0;
      end
      active_q <= '0;
      done_q   <= '0;
    end else begin
      if (slot_en_p0) begin
        val_q[idx_q]   <= val_new_p0;
        steps_q[idx_q] <= steps_new_p0;
        if (term_p0) begin
          active_q[idx_q] <= 1'b0;
          done_q[idx_q]   <= 1'b1;
        end
      end
      if (load_ok) begin
        val_q[i_load_ch]   <= i_alpha;
        delta_q[i_load_ch] <= i_delta;
        floor_q[i_load_ch] <= i_floor;
        steps_q[i_load_ch] <= i_steps;
        if ((i_floor != '0) && (i_alpha <= i_floor)) begin
          active_q[i_load_ch] <= 1'b0;
          done_q[i_load_ch]   <= 1'b1;
        end else begin
          active_q[i_load_ch] <= 1'b1;
          done_q[i_load_ch]   <= 1'b0;
        end
      end
    end
  end

  // Sweep FSM: walks idx over all channels, then strobes o_upd for one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      upd_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_tick) begin
            state_q <= RUN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (i_tick) ovr_q <= 1'b1;
          if (idx_q == LCW'(CH-1)) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            upd_q   <= 1'b1;
          end else begin
            idx_q <= idx_q + LCW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Pack per-channel values onto the output bus.
  always_comb begin
    o_val = '0;
    for (int k = 0; k < CH; k++) o_val[k*W +: W] = val_q[k];
  end

  assign o_active = active_q;
  assign o_done   = done_q;
  assign o_busy   = busy_q;
  assign o_upd    = upd_q;
  assign o_ovr    = ovr_q;

endmodule

// File: tb/tb_gen_exp_mc.sv
// Testbench for gen_exp_mc: directed vector table plus overlap/reset sequences.
module tb_gen_exp_mc;

  localparam int W   = 26;
  localparam int F   = 24;
  localparam int CH  = 4;
  localparam int CW  = 16;
  localparam int LCW = 2;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_load = 1'b0;
  logic [LCW-1:0]  i_load_ch = '0;
  logic [W-1:0]    i_alpha = '0;
  logic [W-1:0]    i_delta = '0;
  logic [CW-1:0]   i_steps = '0;
  logic [W-1:0]    i_floor = '0;
  logic            i_tick = 1'b0;
  logic [CH*W-1:0] o_val;
  logic [CH-1:0]   o_active;
  logic [CH-1:0]   o_done;
  logic            o_busy;
  logic            o_upd;
  logic            o_ovr;

  gen_exp_mc #(.W(W), .F(F), .CH(CH), .CW(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_load_ch(i_load_ch),
    .i_alpha(i_alpha), .i_delta(i_delta), .i_steps(i_steps), .i_floor(i_floor),
    .i_tick(i_tick), .o_val(o_val), .o_active(o_active), .o_done(o_done),
    .o_busy(o_busy), .o_upd(o_upd), .o_ovr(o_ovr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic          ld;
    int            ch;
    logic [W-1:0]  alpha;
    logic [W-1:0]  delta;
    logic [CW-1:0] steps;
    logic [W-1:0]  floor_v;
    logic          tick;
    logic [W-1:0]  exp_val;
    logic          exp_act;
    logic          exp_done;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl [13];

  function automatic logic [W-1:0] chval(input logic [CH*W-1:0] v, input int ch);
    return v[ch*W +: W];
  endfunction

  task automatic do_load(input int ch, input logic [W-1:0] a, input logic [W-1:0] d,
                         input logic [CW-1:0] s, input logic [W-1:0] fl);
    @(negedge i_clk);
    i_load = 1'b1; i_load_ch = LCW'(ch); i_alpha = a; i_delta = d; i_steps = s; i_floor = fl;
    @(negedge i_clk);
    i_load = 1'b0;
  endtask

  // Tick once and check o_upd appears after edge E0+CH and nowhere else.
  task automatic do_tick(input string name);
    logic saw;
    int   extra;
    saw = 1'b0; extra = 0;
    @(negedge i_clk);
    i_tick = 1'b1;
    @(negedge i_clk);
    i_tick = 1'b0;
    for (int c = 1; c <= CH + 2; c++) begin
      @(posedge i_clk); #1;
      if (c == CH) saw = o_upd;
      else if (o_upd) extra++;
    end
    n_vec++;
    if (!saw || extra != 0) begin
      n_bad++;
      $display("FAIL %s upd_timing: upd_at_E0+%0d=%0b extra=%0d, required 1 and 0", name, CH, saw, extra);
    end
  endtask

  task automatic chk_ch(input string name, input int ch, input logic [W-1:0] ev,
                        input logic ea, input logic ed);
    n_vec++;
    if (chval(o_val, ch) !== ev || o_active[ch] !== ea || o_done[ch] !== ed) begin
      n_bad++;
      $display("FAIL %s ch%0d: val=%h act=%b done=%b, required val=%h act=%b done=%b",
               name, ch, chval(o_val, ch), o_active[ch], o_done[ch], ev, ea, ed);
    end
  endtask

  task automatic chk_all_zero(input string name);
    n_vec++;
    if (o_val !== '0 || o_active !== '0 || o_done !== '0 || o_busy !== 1'b0 ||
        o_upd !== 1'b0 || o_ovr !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: val=%h act=%b done=%b busy=%b upd=%b ovr=%b, required all 0",
               name, o_val, o_active, o_done, o_busy, o_upd, o_ovr);
    end
  endtask

  initial begin
    int upd_cnt;
    //             ld  ch alpha        delta        steps floor        tick exp_val      act done
    tbl[0]  = '{1'b1, 0, 26'h1000000, 26'h0800000, 16'd3, 26'h0,       1'b0, 26'h1000000, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 0, 26'h0,       26'h0,       16'd0, 26'h0,       1'b1, 26'h0800000, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 0, 26'h0,       26'h0,       16'd0, 26'h0,       1'b1, 26'h0400000, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 0, 26'h0,       26'h0,       16'd0, 26'h0,       1'b1, 26'h0200000, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 0, 26'h0,       26'h0,       16'd0, 26'h0,       1'b1, 26'h0200000, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1, 26'h0000003, 26'h0800000, 16'd0, 26'h0,       1'b1, 26'h0000002, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1, 26'h0000001, 26'h0800000, 16'd0, 26'h0,       1'b1, 26'h0000001, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 2, 26'h1000000, 26'h0C00000, 16'd0, 26'h0800000, 1'b1, 26'h0C00000, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 2, 26'h0,       26'h0,       16'd0, 26'h0,       1'b1, 26'h0900000, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 2, 26'h0,       26'h0,       16'd0, 26'h0,       1'b1, 26'h06C0000, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 3, 26'h3000000, 26'h2000000, 16'd0, 26'h0,       1'b1, 26'h3FFFFFF, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 3, 26'h0,       26'h0,       16'd0, 26'h0,       1'b1, 26'h3FFFFFF, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1, 26'h0400000, 26'h0800000, 16'd0, 26'h0800000, 1'b0, 26'h0400000, 1'b0, 1'b1};

    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk_all_zero("reset");

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].ld) do_load(tbl[i].ch, tbl[i].alpha, tbl[i].delta, tbl[i].steps, tbl[i].floor_v);
      if (tbl[i].tick) do_tick($sformatf("vec%0d", i));
      @(negedge i_clk);
      chk_ch($sformatf("vec%0d", i), tbl[i].ch, tbl[i].exp_val, tbl[i].exp_act, tbl[i].exp_done);
    end

    // Overlap: second tick two cycles into the sweep is dropped.
    do_load(3, 26'h1000000, 26'h0800000, 16'd0, 26'h0);
    @(negedge i_clk); i_tick = 1'b1;
    @(negedge i_clk); i_tick = 1'b0;
    @(negedge i_clk); i_tick = 1'b1;
    @(negedge i_clk); i_tick = 1'b0;
    upd_cnt = 0;
    for (int c = 0; c < 3 * CH; c++) begin
      @(posedge i_clk); #1;
      if (o_upd) upd_cnt++;
    end
    n_vec++;
    if (upd_cnt != 1 || o_ovr !== 1'b1) begin
      n_bad++;
      $display("FAIL overlap: upd_count=%0d ovr=%b, required 1 and 1", upd_cnt, o_ovr);
    end
    @(negedge i_clk);
    chk_ch("overlap_step", 3, 26'h0800000, 1'b1, 1'b0);

    // Load into ch3 during ch3's own slot: load wins, value stays unstepped.
    @(negedge i_clk); i_tick = 1'b1;
    @(negedge i_clk); i_tick = 1'b0;
    n_vec++;
    if (o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_in_sweep: busy=%b, required 1", o_busy);
    end
    @(posedge i_clk); @(posedge i_clk); @(posedge i_clk);
    @(negedge i_clk);
    i_load = 1'b1; i_load_ch = 2'd3; i_alpha = 26'h1000000; i_delta = 26'h0800000;
    i_steps = 16'd0; i_floor = 26'h0;
    @(negedge i_clk); i_load = 1'b0;
    repeat (3) @(negedge i_clk);
    chk_ch("load_in_slot", 3, 26'h1000000, 1'b1, 1'b0);
    chk_ch("load_in_slot_ch0", 0, 26'h0200000, 1'b0, 1'b1);

    // Reset mid-sweep: everything clears and no o_upd follows.
    @(negedge i_clk); i_tick = 1'b1;
    @(negedge i_clk); i_tick = 1'b0;
    @(negedge i_clk); i_rst = 1'b1;
    @(negedge i_clk); i_rst = 1'b0;
    chk_all_zero("reset_mid_sweep");
    upd_cnt = 0;
    for (int c = 0; c < CH + 3; c++) begin
      @(posedge i_clk); #1;
      if (o_upd) upd_cnt++;
    end
    n_vec++;
    if (upd_cnt != 0) begin
      n_bad++;
      $display("FAIL reset_no_upd: upd_count=%0d, required 0", upd_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gen_exp_mc.md
Name: gen_exp_mc

Overview:
Multi-channel exponential-decay/growth generator, f_k(t) = α_k·δ_k^t, with unsigned fixed-point values.
CH independent channels share one W×W multiplier, time-multiplexed one channel per cycle after each tick.
Each channel stops either after a programmed step count or when its value falls to or below a floor.
It sits in the math/generation group and feeds envelope and scaling consumers that read the packed o_val bus on o_upd.

Parameters:
W, 26, data width; unsigned fixed point Q(W-F).F
F, 24, fractional bits (1.0 = 2^F)
CH, 4, channel count (>=1)
CW, 16, step-counter width

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_load  in  1  load strobe for channel i_load_ch
i_load_ch  in  max(1,$clog2(CH))  channel index to load
i_alpha  in  W  initial value α
i_delta  in  W  per-tick factor δ
i_steps  in  CW  ticks until stop; 0 = unlimited
i_floor  in  W  stop threshold; 0 = disabled
i_tick  in  1  advance all active channels one step
o_val  out  CH*W  current values, channel k at [k*W +: W]
o_active  out  CH  channel k is still stepping
o_done  out  CH  sticky: channel k terminated; cleared by load of k
o_busy  out  1  update sweep in progress
o_upd  out  1  1-cycle strobe: sweep complete, o_val coherent
o_ovr  out  1  sticky: a tick was dropped while busy

Behaviour:
- Reset: all outputs 0; all per-channel val/delta/floor/steps registers 0; FSM in IDLE; channel index 0.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on i_tick; index := 0; o_busy := 1.
  - RUN: processes channel `index` each cycle, then increments index.
  - After channel CH-1: RUN -> IDLE, o_busy := 0, and o_upd is high for exactly the next cycle.
- Sweep timing: tick sampled at edge E0. Channel k's value updates at edge E0+1+k. o_upd is high in the cycle after edge E0+CH, i.e. fixed latency CH+1.
- Inactive channels still occupy their slot in the sweep; their value is unchanged, so latency stays fixed.
- Step arithmetic:
  - p = val·δ, full 2W bits.
  - r = (p + 2^(F-1)) >> F, rounding half-up.
  - If r > 2^W-1, new val = 2^W-1 (saturation); otherwise new val = r.
- Termination, evaluated on the new value in the same slot:
  - If steps_k != 0, decrement it. When it reaches 0: active_k := 0, done_k := 1.
  - If floor_k != 0 and new val <= floor_k: active_k := 0, done_k := 1. The computed value is retained.
  - If both conditions hit in the same slot, the result is the same single termination.
- Load:
  - Writes val := α, δ, floor and steps for channel i_load_ch.
  - Sets active := 1 and done := 0.
  - If floor != 0 and α <= floor, the channel is instead loaded with active := 0 and done := 1.
  - Load takes effect at the next edge and is accepted in any state.
  - Load is ignored if i_load_ch >= CH.
- Simultaneous events:
  - A load to the channel being processed in the same cycle wins; that slot's product is discarded.
  - A load to a channel not yet processed in the current sweep makes that channel step on its new α within the same sweep.
  - i_tick while o_busy=1, including the o_upd cycle being IDLE: it is not busy, so a tick there starts a new sweep. A tick while busy is dropped and sets o_ovr.
  - i_tick together with i_load in IDLE: both are accepted; the load completes before the slot for that channel.
- Reset mid-sweep aborts immediately: IDLE, all channels cleared, no o_upd.
- o_val always reflects the registered values; a value is only considered coherent across channels when o_upd=1.
- δ >= 1.0 (growth) is legal and saturates as above. δ = 0 drives the value to 0 on the first tick.

Test Plan:
1. Rounding, decay and step stop. W=26, F=24. Load ch0 α=0x1000000 (1.0), δ=0x0800000 (0.5), steps=3, floor=0. Apply 3 ticks spaced by ≥6 cycles -> o_val[ch0] = 0x0800000, 0x0400000, 0x0200000. After the third tick, o_active[0]=0 and o_done[0]=1. A 4th tick leaves 0x0200000 unchanged. o_upd is high exactly 5 cycles after each tick edge (CH=4).
2. Half-up rounding. Load ch1 α=0x0000003, δ=0x0800000; tick -> 0x0000002. Load ch1 α=0x0000001, δ=0x0800000; tick -> 0x0000001.
3. Floor stop. Load ch2 α=0x1000000, δ=0x0C00000 (0.75), floor=0x0800000, steps=0. Ticks produce 0x0C00000, then 0x0900000, then 0x06C0000. On the third tick the channel goes inactive with done=1 and keeps 0x06C0000.
4. Saturation. Load ch3 α=0x3000000, δ=0x2000000 (2.0); tick -> 0x3FFFFFF, channel stays active; a further tick keeps 0x3FFFFFF.
5. Overlap. Tick, then a second tick 2 cycles later -> second tick dropped, o_ovr=1, only one o_upd. Load ch3 with α=0x1000000, δ=0x0800000 in the same cycle as ch3's slot -> after the sweep ch3=0x1000000, unstepped. Assert i_rst mid-sweep -> all o_* = 0 and no o_upd.
